ram_req_ctrl: RTL and testbench
===============================

# ram_req_ctrl

Request sequencer that sits directly upstream of the single-port RAM and drives its `wr_en`, `rd_en`, `address` and `data_in` pins. It accepts read and write requests over a valid/ready port and buffers them in a small in-order FIFO. It issues one RAM access at a time and never asserts read and write together. Read data from the RAM's registered `data_out` is captured and returned on a valid/ready response port.

## Interface
- `WIDTH`, 8, data word width; must match the RAM.
- `DEPTH`, 32, RAM word count; address width `AW = $clog2(DEPTH)`.
- `FIFO_DEPTH`, 4, request buffer entries; power of two, at least 2.
- `clk`, input, 1, the single clock; all logic is rising-edge.
- `rst`, input, 1, reset; synchronous, active-high.
- `req_valid`, input, 1, request present.
- `req_ready`, output, 1, FIFO can accept a request.
- `req_write`, input, 1, 1 = write, 0 = read.
- `req_addr`, input, AW, target address.
- `req_wdata`, input, WIDTH, write data; ignored for reads.
- `rsp_valid`, output, 1, read data available.
- `rsp_ready`, input, 1, consumer accepts the response.
- `rsp_rdata`, output, WIDTH, read data.
- `ram_wr_en`, output, 1, to RAM `wr_en`.
- `ram_rd_en`, output, 1, to RAM `rd_en`.
- `ram_address`, output, AW, to RAM `address`.
- `ram_data_in`, output, WIDTH, to RAM `data_in`.
- `ram_data_out`, input, WIDTH, from RAM `data_out`; registered in the RAM, valid the cycle after `rd_en` is sampled.
- `busy`, output, 1, FIFO is non-empty or the FSM is not in IDLE.
- `fifo_count`, output, $clog2(FIFO_DEPTH)+1, number of buffered requests.

## Operation
- **Request acceptance.** A request is accepted on a rising edge where `req_valid && req_ready`.
  - `req_ready = !rst && (fifo_count != FIFO_DEPTH)`. This is combinational and has no bypass; a full FIFO refuses the request even if a pop happens in the same cycle.
  - Requests are executed strictly in arrival order. A read that follows a write to the same address returns the new data.
- **FSM states:** IDLE, ISSUE, RDWAIT, RESP.
- **IDLE.** If the FIFO is non-empty, pop the head into the issue registers and go to ISSUE. Otherwise stay in IDLE.
- **ISSUE.** Exactly one cycle.
  - `ram_address` and `ram_data_in` hold the popped values.
  - `ram_wr_en` is 1 for a write; `ram_rd_en` is 1 for a read.
  - A write goes to IDLE; a read goes to RDWAIT.
- **RDWAIT.** One cycle. `ram_data_out` is valid in this cycle and is captured into `rsp_rdata`. Next state is RESP.
- **RESP.** `rsp_valid` is 1 and `rsp_rdata` is held stable. Leave for IDLE on the edge where `rsp_ready` is 1; otherwise stall with no further RAM activity.
- **RAM strobes.** `ram_wr_en` and `ram_rd_en` are registered, never high together, and high only in ISSUE.
  - Outside ISSUE, `ram_address` and `ram_data_in` hold their last values.
- **FIFO pointers.** They wrap modulo FIFO_DEPTH. A push and a pop in the same cycle leave `fifo_count` unchanged.
- **Reset** (`rst` high at a rising edge) has priority over everything:
  - FSM goes to IDLE and the FIFO is emptied.
  - All outputs go to 0: `rsp_valid`, `rsp_rdata`, `ram_wr_en`, `ram_rd_en`, `ram_address`, `ram_data_in`, `busy`, `fifo_count`.
  - `req_ready` is 0 while `rst` is high.
  - Reset mid-operation drops all pending requests and any held response. A RAM write whose ISSUE cycle has already been sampled by the RAM is not undone.

## Timing
- Request accepted at edge E0 with the FIFO empty and the FSM in IDLE:
  - Pop at E1; ISSUE occupies the cycle E1–E2; the RAM samples the strobe at E2.
  - Write: the memory is updated at E2 and the FSM is back in IDLE after E2.
  - Read: RAM `data_out` updates at E2, capture happens at E3, and `rsp_valid` is high from E3 onward.
- Throughput:
  - Back-to-back writes complete one every 2 cycles (IDLE, ISSUE).
  - Reads take 4 cycles each when `rsp_ready` is held at 1.
- `rsp_valid` rises 3 cycles after the request handshake edge at minimum. Each additional stalled RESP cycle adds one cycle of latency for every queued request.
- With `rsp_ready` held at 0, the FIFO fills to FIFO_DEPTH and `req_ready` drops the cycle after the fourth push (for FIFO_DEPTH = 4).

## Test plan
- **Reset.** Assert `rst` for 2 cycles with `req_valid` = 1 → all outputs are 0 and `req_ready` is 0; after release `req_ready` is 1, `fifo_count` is 0, and no RAM strobe occurs.
- **Write then read, same address.** Write 0xA5 to address 3, then read address 3 → `ram_wr_en` is high for exactly 1 cycle with `ram_address` = 3; `rsp_valid` rises 3 cycles after the read handshake with `rsp_rdata` = 0xA5; `ram_wr_en` and `ram_rd_en` are never high together.
- **Full and backpressure.** With `rsp_ready` = 0, push 6 reads of addresses 0–5 → the first enters RESP, 4 are buffered and `req_ready` = 0; raise `rsp_ready` → responses return in address order 0–5 with no loss or duplication.
- **Wrap-around.** Run 20 alternating writes and reads to addresses 0 and 31 (DEPTH − 1) → pointers wrap several times and every read returns the data last written to that address.
- **Simultaneous push and pop.** Push a request on the same edge the FSM pops from a 2-entry FIFO → `fifo_count` stays at 2.
- **Reset mid-operation.** Assert `rst` during RESP with 3 requests queued → `rsp_valid` is 0 and `fifo_count` is 0 next cycle; no stale response appears after release.

Source files
------------

// File: rtl/ram_req_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// ram_req_ctrl : in-order request sequencer in front of a single-port RAM.
// Rev 1.0
// ----------------------------------------------------------------------------
module ram_req_ctrl #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 32,
  parameter int FIFO_DEPTH = 4,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_rdata,
  output logic             ram_wr_en,
  output logic             ram_rd_en,
  output logic [AW-1:0]    ram_address,
  output logic [WIDTH-1:0] ram_data_in,
  input  logic [WIDTH-1:0] ram_data_out,
  output logic             busy,
  output logic [CW-1:0]    fifo_count
);

  localparam int PW = CW - 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_RDWAIT = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic             fifo_wr_q   [FIFO_DEPTH];
  logic [AW-1:0]    fifo_addr_q [FIFO_DEPTH];
  logic [WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  logic             is_wr_q;
  logic [AW-1:0]    addr_q;
  logic [WIDTH-1:0] wdata_q;
  logic             wr_en_q;
  logic             rd_en_q;
  logic [WIDTH-1:0] rdata_q;

  logic push;
  logic pop;
  logic fifo_empty;

  // No bypass: a full FIFO refuses even when a pop is happening this cycle.
  assign req_ready  = !rst && (count_q != CW'(FIFO_DEPTH));
  assign push       = req_valid && req_ready;
  assign fifo_empty = (count_q == '0);

  // Request buffer; pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_wr_q[wr_ptr_q]   <= req_write;
        fifo_addr_q[wr_ptr_q] <= req_addr;
        fifo_data_q[wr_ptr_q] <= req_wdata;
        wr_ptr_q              <= wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = is_wr_q ? S_IDLE : S_RDWAIT;
      end
      S_RDWAIT: begin
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Strobes are set by the pop so they are high exactly for the ISSUE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      is_wr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wr_en_q <= 1'b0;
      rd_en_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      wr_en_q <= pop && fifo_wr_q[rd_ptr_q];
      rd_en_q <= pop && !fifo_wr_q[rd_ptr_q];
      if (pop) begin
        is_wr_q <= fifo_wr_q[rd_ptr_q];
        addr_q  <= fifo_addr_q[rd_ptr_q];
        wdata_q <= fifo_data_q[rd_ptr_q];
      end
      if (state_q == S_RDWAIT) begin
        rdata_q <= ram_data_out;
      end
    end
  end

  assign ram_wr_en   = wr_en_q;
  assign ram_rd_en   = rd_en_q;
  assign ram_address = addr_q;
  assign ram_data_in = wdata_q;
  assign rsp_valid   = (state_q == S_RESP);
  assign rsp_rdata   = rdata_q;
  assign busy        = !fifo_empty || (state_q != S_IDLE);
  assign fifo_count  = count_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_req_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ram_req_ctrl : table vectors, directed corner sequences and random
// traffic against a queue-based model of ram_req_ctrl plus a behavioural RAM.
// ----------------------------------------------------------------------------
module tb_ram_req_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic [4:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_rdata;
  logic       ram_wr_en;
  logic       ram_rd_en;
  logic [4:0] ram_address;
  logic [7:0] ram_data_in;
  logic [7:0] ram_data_out;
  logic       busy;
  logic [2:0] fifo_count;

  always #5 clk = ~clk;

  ram_req_ctrl #(.WIDTH(8), .DEPTH(32), .FIFO_DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .ram_wr_en    (ram_wr_en),
    .ram_rd_en    (ram_rd_en),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_data_out (ram_data_out),
    .busy         (busy),
    .fifo_count   (fifo_count)
  );

  // Behavioural single-port RAM with registered read data.
  logic       tb_clear;
  logic [7:0] ram_mem [32];
  always @(posedge clk) begin
    if (tb_clear) begin
      for (int i = 0; i < 32; i++) ram_mem[i] <= 8'h00;
      ram_data_out <= 8'h00;
    end else begin
      if (ram_wr_en) ram_mem[ram_address] <= ram_data_in;
      if (ram_rd_en) ram_data_out <= ram_mem[ram_address];
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: requests take effect in arrival order, so each read
  // sees the memory as left by every request accepted before it.
  typedef struct packed {
    logic       wr;
    logic [4:0] addr;
    logic [7:0] data;
  } op_t;

  logic [7:0] model_mem [32];
  logic [7:0] exp_q [$];
  op_t        op_q  [$];
  bit         mon_en = 1'b0;
  int         rsp_seen = 0;

  initial begin
    op_t o;
    bit  rst_last;
    rst_last = 1'b0;
    forever begin
      @(negedge clk);
      // Queued writes are dropped by reset; an issued one still lands.
      if (rst || rst_last) model_mem = ram_mem;
      if (mon_en) begin
        check("strobe_excl", ram_wr_en & ram_rd_en, 0);
        if (ram_wr_en || ram_rd_en) begin
          if (op_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL strobe_unexpected: got wr=%0b rd=%0b addr=%0d expected no strobe at %0t",
                     ram_wr_en, ram_rd_en, ram_address, $time);
          end else begin
            o = op_q.pop_front();
            check("strobe_kind", ram_wr_en, o.wr);
            check("strobe_addr", ram_address, o.addr);
            if (o.wr) check("strobe_wdata", ram_data_in, o.data);
          end
        end
        if (rst) begin
          exp_q.delete();
          op_q.delete();
        end else begin
          if (rsp_valid && rsp_ready) begin
            rsp_seen++;
            if (exp_q.size() == 0) begin
              n_checks++;
              n_fail++;
              $display("FAIL rsp_unexpected: got rdata=0x%0h expected no response at %0t", rsp_rdata, $time);
            end else begin
              check("rsp_rdata", rsp_rdata, exp_q.pop_front());
            end
          end
          if (req_valid && req_ready) begin
            op_q.push_back('{wr: req_write, addr: req_addr, data: req_wdata});
            if (req_write) model_mem[req_addr] = req_wdata;
            else           exp_q.push_back(model_mem[req_addr]);
          end
        end
      end
      rst_last = rst;
    end
  end

  // Entered and left at posedge+1.
  task automatic send(input logic w, input logic [4:0] a, input logic [7:0] d);
    bit ok;
    ok        = 1'b0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: got req_ready=0 expected 1 within 300 cycles");
    end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clk);
      if (!busy && !rsp_valid) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: got busy=%0b expected 0 within 300 cycles", busy);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp();
    bit ok;
    ok = 1'b0;
    for (int t = 0; t < 100 && !ok; t++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1'b1;
    end
    if (!ok) begin
      n_checks++;
      n_fail++;
      $display("FAIL rsp_timeout: got rsp_valid=0 expected 1 within 100 cycles");
    end
  endtask

  typedef struct {
    logic       wr;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs [8];
  bit   rand_done;

  initial begin
    int base;
    vecs[0] = '{1'b1, 5'd3,  8'hA5, 8'h00};
    vecs[1] = '{1'b0, 5'd3,  8'h00, 8'hA5};
    vecs[2] = '{1'b1, 5'd31, 8'h3C, 8'h00};
    vecs[3] = '{1'b0, 5'd31, 8'h00, 8'h3C};
    vecs[4] = '{1'b1, 5'd0,  8'h5A, 8'h00};
    vecs[5] = '{1'b0, 5'd0,  8'h00, 8'h5A};
    vecs[6] = '{1'b0, 5'd3,  8'hFF, 8'hA5};
    vecs[7] = '{1'b0, 5'd1,  8'h00, 8'h00};

    // Reset with a request pending.
    rst = 1'b1; tb_clear = 1'b1; rsp_ready = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 5'd7; req_wdata = 8'h77;
    @(posedge clk); #1;
    mon_en = 1'b1;
    @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_rdata", rsp_rdata, 0);
    check("rst_wr_en", ram_wr_en, 0);
    check("rst_rd_en", ram_rd_en, 0);
    check("rst_address", ram_address, 0);
    check("rst_data_in", ram_data_in, 0);
    check("rst_busy", busy, 0);
    check("rst_count", fifo_count, 0);
    @(posedge clk); #1;
    tb_clear = 1'b0;
    @(negedge clk);
    check("rst_req_ready2", req_ready, 0);
    check("rst_count2", fifo_count, 0);
    @(posedge clk); #1;
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    check("rel_req_ready", req_ready, 1);
    check("rel_count", fifo_count, 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rel_no_strobe", ram_wr_en | ram_rd_en, 0);
    end
    @(posedge clk); #1;

    // Isolated transactions: strobe timing and read latency.
    rsp_ready = 1'b1;
    for (int v = 0; v < 8; v++) begin
      wait_idle();
      send(vecs[v].wr, vecs[v].addr, vecs[v].wdata);
      @(negedge clk);
      check("vec_count", fifo_count, 1);
      check("vec_e0_strobe", ram_wr_en | ram_rd_en, 0);
      @(negedge clk);
      check("vec_wr_en", ram_wr_en, vecs[v].wr);
      check("vec_rd_en", ram_rd_en, !vecs[v].wr);
      check("vec_address", ram_address, vecs[v].addr);
      if (vecs[v].wr) check("vec_data_in", ram_data_in, vecs[v].wdata);
      @(negedge clk);
      check("vec_e2_strobe", ram_wr_en | ram_rd_en, 0);
      check("vec_e2_rsp_valid", rsp_valid, 0);
      if (vecs[v].wr) check("vec_wr_busy", busy, 0);
      if (!vecs[v].wr) begin
        @(negedge clk);
        check("vec_rsp_valid", rsp_valid, 1);
        check("vec_rsp_rdata", rsp_rdata, vecs[v].exp);
      end
      @(posedge clk); #1;
    end

    // Full FIFO and backpressure.
    wait_idle();
    for (int i = 0; i < 6; i++) send(1'b1, 5'(i), 8'(8'h40 + i));
    wait_idle();
    rsp_ready = 1'b0;
    base = rsp_seen;
    for (int i = 0; i < 5; i++) send(1'b0, 5'(i), 8'h00);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd5;
    @(negedge clk);
    check("full_req_ready", req_ready, 0);
    check("full_count", fifo_count, 4);
    check("full_rsp_valid", rsp_valid, 1);
    check("full_rsp_rdata", rsp_rdata, 8'h40);
    repeat (3) @(negedge clk);
    check("full_hold_rdata", rsp_rdata, 8'h40);
    check("full_hold_ready", req_ready, 0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    send(1'b0, 5'd5, 8'h00);
    wait_idle();
    check("full_rsp_total", rsp_seen - base, 6);

    // Alternating traffic to both address extremes; pointers wrap repeatedly.
    for (int k = 0; k < 20; k++)
      send(!k[0], ((k / 2) % 2) ? 5'd31 : 5'd0, 8'($urandom_range(0, 255)));
    wait_idle();

    // Push on the same edge the FSM pops with two entries buffered.
    rsp_ready = 1'b0;
    send(1'b0, 5'd7, 8'h00);
    send(1'b0, 5'd8, 8'h00);
    send(1'b0, 5'd9, 8'h00);
    wait_rsp();
    check("pp_count_before", fifo_count, 2);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd10;
    @(negedge clk);
    check("pp_count_idle", fifo_count, 2);
    check("pp_req_ready", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("pp_count_after", fifo_count, 2);
    check("pp_rd_en", ram_rd_en, 1);
    wait_idle();

    // Reset during RESP with three requests queued.
    rsp_ready = 1'b0;
    for (int i = 11; i < 15; i++) send(1'b0, 5'(i), 8'h00);
    wait_rsp();
    check("mid_count_before", fifo_count, 3);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rsp_valid", rsp_valid, 0);
    check("mid_count", fifo_count, 0);
    check("mid_busy", busy, 0);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("mid_no_stale", rsp_valid | ram_rd_en | ram_wr_en, 0);
    end
    @(posedge clk); #1;

    // Random traffic with random response backpressure.
    rand_done = 1'b0;
    fork
      begin
        for (int n = 0; n < 150; n++) begin
          logic [4:0] a;
          case ($urandom_range(0, 4))
            0:       a = 5'd0;
            1:       a = 5'd31;
            2:       a = 5'd5;
            default: a = 5'($urandom_range(0, 31));
          endcase
          send(1'($urandom_range(0, 1)), a, 8'($urandom_range(0, 255)));
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
          end
        end
        rand_done = 1'b1;
      end
      begin
        for (int c = 0; c < 20000 && !rand_done; c++) begin
          @(posedge clk); #1;
          rsp_ready = ($urandom_range(0, 9) < 7);
        end
        rsp_ready = 1'b1;
      end
    join
    wait_idle();
    repeat (2) @(negedge clk);
    check("end_exp_empty", exp_q.size(), 0);
    check("end_op_empty", op_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
